instr_rom_arbiter: RTL and testbench
====================================

# instr_rom_arbiter

Shares the single combinational read port of the instruction ROM between two requesters: the IF-stage fetch port (F) and the MEM-stage text-section read port (D, used for PC-relative constant loads from `.text`). Each cycle it grants at most one request, drives the ROM address, and registers the 32-bit word into a one-cycle response pulse for the granted port. D has fixed priority, bounded by an anti-starvation counter for F. It also checks alignment and range, and supports a fetch flush.

## Interface
- XLEN, default `XLEN_64b: 2-bit XLEN encoding. Address width AW = 1<<(XLEN+4), i.e. 32 or 64.
- TEXT_HI, default `TEXT_HI: highest valid byte address of the ROM.
- MAX_WAIT, default 4: number of consecutive cycles F may be denied before F is forced to win. Range 1..15.
- i_clk  in  1  single clock; all state changes on its rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_f_req  in  1  fetch request valid.
- i_f_adr  in  AW  fetch byte address.
- o_f_gnt  out  1  fetch request accepted this cycle (combinational).
- o_f_rsp_vld  out  1  fetch response valid (one-cycle pulse).
- o_f_rsp_instr  out  32  fetched word.
- o_f_rsp_err  out  1  fetch address misaligned or out of range.
- i_f_flush  in  1  discard any fetch response pending for the next cycle.
- i_d_req  in  1  data read request valid.
- i_d_adr  in  AW  data byte address.
- o_d_gnt  out  1  data request accepted this cycle (combinational).
- o_d_rsp_vld  out  1  data response valid (one-cycle pulse).
- o_d_rsp_data  out  32  read word.
- o_d_rsp_err  out  1  data address misaligned or out of range.
- o_rom_adr  out  AW  address to the ROM.
- i_rom_instr  in  32  ROM read data, combinational from o_rom_adr.

## Operation
- **Grant rule.**
  - o_d_gnt = i_d_req & ~force_f.
  - o_f_gnt = i_f_req & (~i_d_req | force_f).
  - At most one grant is active per cycle.
- **force_f.** force_f = (wait_cnt == MAX_WAIT).
- **wait_cnt** (4-bit, reset 0):
  - Increments when i_f_req=1 and o_f_gnt=0.
  - Clears when o_f_gnt=1 or i_f_req=0.
  - Saturates at MAX_WAIT.
- **ROM address.**
  - o_rom_adr = granted port's address.
  - With no grant it holds its last registered value, so the ROM input does not toggle.
- **Error check** (evaluated on the granted address):
  - err = (adr[1:0] != 0) | (adr > TEXT_HI-3).
  - On err, the response data is 0 and the err flag is set.
  - An erroring request still consumes its grant.
- **Response register.**
  - On a grant, capture {port, err, err ? 0 : i_rom_instr} at the clock edge.
  - The next cycle, assert the matching rsp_vld for exactly one cycle.
  - Data and err hold their value until the next response on the same port.
- **Flush.**
  - If i_f_flush=1 in the cycle of a F grant, o_f_rsp_vld is suppressed the following cycle.
  - If i_f_flush=1 while o_f_rsp_vld=1, that response is still delivered. The flush acts only on the grant cycle.
  - D is unaffected by flush.
- **No backpressure on responses.** Requesters must sample in the valid cycle.
- **Reset** (asynchronous assert, synchronous release):
  - All outputs go to 0, and o_rom_adr = 0.
  - wait_cnt = 0.
  - Any pending response is discarded.

## Timing
- Latency from grant to response is 1 cycle: request and grant in cycle N, rsp_vld in cycle N+1.
- Throughput is one access per cycle total. Back-to-back grants to the same or alternating ports are legal.
- o_f_gnt and o_d_gnt are combinational from i_f_req, i_d_req and registered wait_cnt. They have no path from the rsp outputs.
- With both requesters held continuously, the grant pattern is D×MAX_WAIT followed by F×1, repeating.
- Reset asserted mid-operation: rsp_vld drops in the same cycle, asynchronously. The first grant is possible in the first cycle after deassertion.
- Simultaneous requests when wait_cnt < MAX_WAIT: D wins and wait_cnt increments.

## Test plan
- **F only.** i_f_req=1 at 0x0, 0x4, 0x8 on consecutive cycles → grants in each of the 3 cycles; o_f_rsp_instr equals ROM words 0,1,2 in cycles +1..+3; o_f_rsp_err=0.
- **Contention, MAX_WAIT=4.** Both requests held for 10 cycles → grant sequence D,D,D,D,F,D,D,D,D,F; wait_cnt peaks at 4.
- **Errors.** i_d_adr=0x6 → o_d_rsp_err=1 and data 0 one cycle later. i_f_adr=TEXT_HI-1 → o_f_rsp_err=1.
- **Flush.**
  - F granted at 0x10 with i_f_flush=1 → no o_f_rsp_vld the next cycle.
  - A D grant in the same sequence still returns valid data.
- **Reset mid-stream.** i_rst_n low in the cycle o_d_rsp_vld=1 → o_d_rsp_vld=0 immediately and wait_cnt=0. After release, the first request is granted in its first cycle.
- **Idle hold.** No requests for 5 cycles → o_rom_adr is unchanged, no rsp_vld, and no grants.

Source files
------------

// File: rtl/instr_rom_arbiter_if.sv
// Bundle between the instruction-ROM arbiter and its two requesters
// (IF-stage fetch F, MEM-stage text read D) plus the shared ROM port.
interface instr_rom_arbiter_if #(
    parameter int AW = 64
);
    logic          i_f_req;
    logic [AW-1:0] i_f_adr;
    logic          o_f_gnt;
    logic          o_f_rsp_vld;
    logic [31:0]   o_f_rsp_instr;
    logic          o_f_rsp_err;
    logic          i_f_flush;

    logic          i_d_req;
    logic [AW-1:0] i_d_adr;
    logic          o_d_gnt;
    logic          o_d_rsp_vld;
    logic [31:0]   o_d_rsp_data;
    logic          o_d_rsp_err;

    logic [AW-1:0] o_rom_adr;
    logic [31:0]   i_rom_instr;

    // Arbiter side
    modport slave (
        input  i_f_req, i_f_adr, i_f_flush, i_d_req, i_d_adr, i_rom_instr,
        output o_f_gnt, o_f_rsp_vld, o_f_rsp_instr, o_f_rsp_err,
        output o_d_gnt, o_d_rsp_vld, o_d_rsp_data, o_d_rsp_err, o_rom_adr
    );

    // Requester / ROM side
    modport master (
        output i_f_req, i_f_adr, i_f_flush, i_d_req, i_d_adr, i_rom_instr,
        input  o_f_gnt, o_f_rsp_vld, o_f_rsp_instr, o_f_rsp_err,
        input  o_d_gnt, o_d_rsp_vld, o_d_rsp_data, o_d_rsp_err, o_rom_adr
    );
endinterface

// File: rtl/instr_rom_arbiter.sv
// Shares the single combinational instruction-ROM read port between the
// fetch port F and the text-data port D. D has fixed priority; F is forced
// through after MAX_WAIT consecutive denials. Each grant produces a one-cycle
// registered response pulse on the granted port, with alignment/range check.
module instr_rom_arbiter #(
    parameter logic [1:0]  XLEN     = 2'd2,
    parameter logic [63:0] TEXT_HI  = 64'h0000_0000_0000_0FFF,
    parameter int          MAX_WAIT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    instr_rom_arbiter_if.slave   bus
);
    localparam int            AW        = 1 << (XLEN + 2'd0 + 4);
    localparam logic [3:0]    MAX_WAIT_W = 4'(MAX_WAIT);
    // Highest byte address at which a full 32-bit word still fits
    localparam logic [AW-1:0] LAST_WORD  = AW'(TEXT_HI - 64'd3);

    // Misaligned or past the end of the ROM
    function automatic logic adr_err(input logic [AW-1:0] adr);
        return (adr[1:0] != 2'b00) || (adr > LAST_WORD);
    endfunction

    logic [3:0]    wait_cnt_r;
    logic [AW-1:0] rom_adr_r;
    logic          f_vld_r;
    logic          f_err_r;
    logic [31:0]   f_data_r;
    logic          d_vld_r;
    logic          d_err_r;
    logic [31:0]   d_data_r;

    logic          force_f_s;
    logic          f_gnt_s;
    logic          d_gnt_s;
    logic [AW-1:0] adr_s;
    logic          err_s;
    logic [31:0]   word_s;

    // Grant decision, ROM address mux and error/data qualification
    always_comb begin
        force_f_s = 1'b0;
        f_gnt_s   = 1'b0;
        d_gnt_s   = 1'b0;
        adr_s     = rom_adr_r;
        err_s     = 1'b0;
        word_s    = 32'd0;

        force_f_s = (wait_cnt_r == MAX_WAIT_W);
        d_gnt_s   = bus.i_d_req & ~force_f_s;
        f_gnt_s   = bus.i_f_req & (~bus.i_d_req | force_f_s);

        // Without a grant the ROM address holds so the ROM input stays quiet
        if (d_gnt_s) begin
            adr_s = bus.i_d_adr;
        end else if (f_gnt_s) begin
            adr_s = bus.i_f_adr;
        end else begin
            adr_s = rom_adr_r;
        end

        err_s = adr_err(adr_s);
        if (err_s) begin
            word_s = 32'd0;
        end else begin
            word_s = bus.i_rom_instr;
        end
    end

    assign bus.o_f_gnt       = f_gnt_s;
    assign bus.o_d_gnt       = d_gnt_s;
    assign bus.o_rom_adr     = adr_s;
    assign bus.o_f_rsp_vld   = f_vld_r;
    assign bus.o_f_rsp_err   = f_err_r;
    assign bus.o_f_rsp_instr = f_data_r;
    assign bus.o_d_rsp_vld   = d_vld_r;
    assign bus.o_d_rsp_err   = d_err_r;
    assign bus.o_d_rsp_data  = d_data_r;

    // Starvation counter, held ROM address and per-port response registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt_r <= 4'd0;
            rom_adr_r  <= '0;
            f_vld_r    <= 1'b0;
            f_err_r    <= 1'b0;
            f_data_r   <= 32'd0;
            d_vld_r    <= 1'b0;
            d_err_r    <= 1'b0;
            d_data_r   <= 32'd0;
        end else begin
            if (!bus.i_f_req || f_gnt_s) begin
                wait_cnt_r <= 4'd0;
            end else if (wait_cnt_r != MAX_WAIT_W) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end

            rom_adr_r <= adr_s;

            // A flushed fetch is dropped entirely, so the last delivered
            // fetch response stays visible on the data/err outputs
            f_vld_r <= f_gnt_s & ~bus.i_f_flush;
            if (f_gnt_s && !bus.i_f_flush) begin
                f_err_r  <= err_s;
                f_data_r <= word_s;
            end else begin
                f_err_r  <= f_err_r;
                f_data_r <= f_data_r;
            end

            d_vld_r <= d_gnt_s;
            if (d_gnt_s) begin
                d_err_r  <= err_s;
                d_data_r <= word_s;
            end else begin
                d_err_r  <= d_err_r;
                d_data_r <= d_data_r;
            end
        end
    end
endmodule

// File: tb/tb_instr_rom_arbiter.sv
// Directed bench for instr_rom_arbiter: fetch-only stream, contention
// pattern, address errors, flush, mid-stream reset and idle hold.
module tb_instr_rom_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   max_wait;

    instr_rom_arbiter_if #(.AW(64)) bus ();

    instr_rom_arbiter #(
        .XLEN    (2'd2),
        .TEXT_HI (64'h0000_0000_0000_0FFF),
        .MAX_WAIT(4)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // ROM model: word at byte address a is 0x1357_xxxx with the low 16 address bits
    assign bus.i_rom_instr = {16'h1357, bus.o_rom_adr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the edge, then apply this cycle's request inputs
    task automatic step(input logic f_req, input logic [63:0] f_adr,
                        input logic d_req, input logic [63:0] d_adr,
                        input logic flush);
        @(posedge clk);
        #1;
        bus.i_f_req   = f_req;
        bus.i_f_adr   = f_adr;
        bus.i_d_req   = d_req;
        bus.i_d_adr   = d_adr;
        bus.i_f_flush = flush;
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        max_wait = 0;
        rst_n = 1'b0;
        bus.i_f_req = 1'b0;
        bus.i_f_adr = 64'd0;
        bus.i_d_req = 1'b0;
        bus.i_d_adr = 64'd0;
        bus.i_f_flush = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_rom_adr", bus.o_rom_adr, 64'd0);
        check("rst_f_vld", {63'd0, bus.o_f_rsp_vld}, 64'd0);
        check("rst_d_vld", {63'd0, bus.o_d_rsp_vld}, 64'd0);
        check("rst_d_data", {32'd0, bus.o_d_rsp_data}, 64'd0);
        check("rst_wait", {60'd0, dut.wait_cnt_r}, 64'd0);
        rst_n = 1'b1;

        // F only, three consecutive fetches
        step(1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        check("fonly_gnt0", {63'd0, bus.o_f_gnt}, 64'd1);
        check("fonly_adr0", bus.o_rom_adr, 64'h0);
        step(1'b1, 64'h4, 1'b0, 64'h0, 1'b0);
        check("fonly_gnt1", {63'd0, bus.o_f_gnt}, 64'd1);
        check("fonly_vld0", {63'd0, bus.o_f_rsp_vld}, 64'd1);
        check("fonly_instr0", {32'd0, bus.o_f_rsp_instr}, 64'h1357_0000);
        step(1'b1, 64'h8, 1'b0, 64'h0, 1'b0);
        check("fonly_gnt2", {63'd0, bus.o_f_gnt}, 64'd1);
        check("fonly_instr1", {32'd0, bus.o_f_rsp_instr}, 64'h1357_0004);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        check("fonly_instr2", {32'd0, bus.o_f_rsp_instr}, 64'h1357_0008);
        check("fonly_err", {63'd0, bus.o_f_rsp_err}, 64'd0);
        check("fonly_d_vld", {63'd0, bus.o_d_rsp_vld}, 64'd0);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        check("fonly_vld_end", {63'd0, bus.o_f_rsp_vld}, 64'd0);

        // Contention: expect D,D,D,D,F,D,D,D,D,F
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 64'h20, 1'b1, 64'h40, 1'b0);
            if (int'(dut.wait_cnt_r) > max_wait) max_wait = int'(dut.wait_cnt_r);
            check($sformatf("cont_f_gnt%0d", i), {63'd0, bus.o_f_gnt},
                  (i == 4 || i == 9) ? 64'd1 : 64'd0);
            check($sformatf("cont_d_gnt%0d", i), {63'd0, bus.o_d_gnt},
                  (i == 4 || i == 9) ? 64'd0 : 64'd1);
        end
        check("cont_wait_peak", 64'(max_wait), 64'd4);

        // Errors
        step(1'b0, 64'h0, 1'b1, 64'h6, 1'b0);
        check("err_d_gnt", {63'd0, bus.o_d_gnt}, 64'd1);
        step(1'b1, 64'hFFE, 1'b0, 64'h0, 1'b0);
        check("err_d_vld", {63'd0, bus.o_d_rsp_vld}, 64'd1);
        check("err_d_err", {63'd0, bus.o_d_rsp_err}, 64'd1);
        check("err_d_data", {32'd0, bus.o_d_rsp_data}, 64'd0);
        step(1'b0, 64'h0, 1'b1, 64'h1000, 1'b0);
        check("err_f_vld", {63'd0, bus.o_f_rsp_vld}, 64'd1);
        check("err_f_err", {63'd0, bus.o_f_rsp_err}, 64'd1);
        check("err_f_instr", {32'd0, bus.o_f_rsp_instr}, 64'd0);
        step(1'b0, 64'h0, 1'b1, 64'hFFC, 1'b0);
        check("err_range_err", {63'd0, bus.o_d_rsp_err}, 64'd1);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        check("last_word_err", {63'd0, bus.o_d_rsp_err}, 64'd0);
        check("last_word_data", {32'd0, bus.o_d_rsp_data}, 64'h1357_0FFC);

        // Flush on the grant cycle, then a D grant while flush stays high
        step(1'b1, 64'h10, 1'b0, 64'h0, 1'b1);
        check("flush_f_gnt", {63'd0, bus.o_f_gnt}, 64'd1);
        step(1'b0, 64'h0, 1'b1, 64'h14, 1'b1);
        check("flush_f_vld", {63'd0, bus.o_f_rsp_vld}, 64'd0);
        step(1'b1, 64'h18, 1'b0, 64'h0, 1'b0);
        check("flush_d_vld", {63'd0, bus.o_d_rsp_vld}, 64'd1);
        check("flush_d_data", {32'd0, bus.o_d_rsp_data}, 64'h1357_0014);
        // Flush raised during the valid cycle does not cancel it
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        check("flush_late_vld", {63'd0, bus.o_f_rsp_vld}, 64'd1);
        check("flush_late_instr", {32'd0, bus.o_f_rsp_instr}, 64'h1357_0018);

        // Reset mid-stream while a D response is valid
        step(1'b1, 64'h20, 1'b1, 64'h40, 1'b0);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        check("mid_d_vld_pre", {63'd0, bus.o_d_rsp_vld}, 64'd1);
        check("mid_wait_pre", {60'd0, dut.wait_cnt_r}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_d_vld_rst", {63'd0, bus.o_d_rsp_vld}, 64'd0);
        check("mid_wait_rst", {60'd0, dut.wait_cnt_r}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 64'h24, 1'b0, 64'h0, 1'b0);
        check("post_rst_gnt", {63'd0, bus.o_f_gnt}, 64'd1);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        check("post_rst_vld", {63'd0, bus.o_f_rsp_vld}, 64'd1);
        check("post_rst_instr", {32'd0, bus.o_f_rsp_instr}, 64'h1357_0024);

        // Idle hold: address stays at the last granted value
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
            check($sformatf("idle_adr%0d", i), bus.o_rom_adr, 64'h24);
            check($sformatf("idle_gnt%0d", i), {62'd0, bus.o_f_gnt, bus.o_d_gnt}, 64'd0);
            check($sformatf("idle_vld%0d", i), {62'd0, bus.o_f_rsp_vld, bus.o_d_rsp_vld}, 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
